johnson_seq_checker: RTL and testbench

//  Receive side of the 3-bit, 6-state count bus (000>001>011>111>110>100>000).

---
 rtl/johnson_seq_checker.sv | 170 +++++++++++++++++
 tb/tb_johnson_seq_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_seq_checker.sv
// Receive-side checker for the 3-bit, 6-state Johnson count bus: decode, illegal-code and step checking.
// Build option: define DIR_DETECT_EN to accept reverse stepping and report the detected direction.
module johnson_seq_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [2:0]       code,
  output logic [2:0]       index,
  output logic             locked,
  output logic             dir,
  output logic             illegal_err,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LastGood = CNT_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic code_legal(input logic [2:0] c);
    return (c != 3'b010) && (c != 3'b101);
  endfunction

  function automatic logic [2:0] code_to_index(input logic [2:0] c);
    logic [2:0] idx;
    unique case (c)
      3'b000:  idx = 3'd0;
      3'b001:  idx = 3'd1;
      3'b011:  idx = 3'd2;
      3'b111:  idx = 3'd3;
      3'b110:  idx = 3'd4;
      3'b100:  idx = 3'd5;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  // A Johnson counter steps by shifting left and feeding back the inverted MSB.
  function automatic logic [2:0] johnson_next(input logic [2:0] c);
    return {c[1:0], ~c[2]};
  endfunction

  function automatic logic [2:0] johnson_prev(input logic [2:0] c);
    return {~c[0], c[2:1]};
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic             dir_q, dir_d;
  logic [2:0]       index_q, index_d;
  logic             locked_q, locked_d;
  logic             ill_q, ill_d;
  logic             seq_q, seq_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic legal, is_hold, is_fwd, is_rev, rev_ok;
  logic first_ok, in_dir, step_ok;

`ifdef DIR_DETECT_EN
  assign rev_ok = 1'b1;
`else
  assign rev_ok = 1'b0;
`endif

  assign legal   = code_legal(code);
  assign is_hold = (code == last_q);
  assign is_fwd  = (code == johnson_next(last_q));
  assign is_rev  = (code == johnson_prev(last_q));

  // The first step after a capture picks the direction; later steps must follow it.
  assign first_ok = is_fwd | (is_rev & rev_ok);
  assign in_dir   = dir_q ? (is_rev & rev_ok) : is_fwd;
  assign step_ok  = (good_q == '0) ? first_ok : in_dir;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    good_d  = good_q;
    dir_d   = dir_q;
    index_d = index_q;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    if (code_valid) begin
      if (!legal) begin
        ill_d   = 1'b1;
        good_d  = '0;
        state_d = HUNT;
      end else begin
        index_d = code_to_index(code);
        unique case (state_q)
          HUNT: begin
            last_d  = code;
            good_d  = '0;
            state_d = SYNC;
          end
          SYNC: begin
            if (!is_hold) begin
              last_d = code;
              if (step_ok) begin
                good_d = good_q + CNT_W'(1);
                if (good_q == '0) dir_d = is_rev;
                if (good_q == LastGood) state_d = LOCKED;
              end else begin
                good_d = '0;
              end
            end
          end
          LOCKED: begin
            if (!is_hold) begin
              last_d = code;
              if (!in_dir) begin
                seq_d   = 1'b1;
                good_d  = '0;
                state_d = SYNC;
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_comb begin
    locked_d = (state_d == LOCKED);
    err_d    = err_q;
    if ((ill_d | seq_d) && !(&err_q)) err_d = err_q + ERR_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      last_q   <= 3'b000;
      good_q   <= '0;
      dir_q    <= 1'b0;
      index_q  <= 3'd0;
      locked_q <= 1'b0;
      ill_q    <= 1'b0;
      seq_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      good_q   <= good_d;
      dir_q    <= dir_d;
      index_q  <= index_d;
      locked_q <= locked_d;
      ill_q    <= ill_d;
      seq_q    <= seq_d;
      err_q    <= err_d;
    end
  end

  assign index       = index_q;
  assign locked      = locked_q;
  assign dir         = dir_q;
  assign illegal_err = ill_q;
  assign seq_err     = seq_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_johnson_seq_checker.sv
// Directed bench for johnson_seq_checker: position-arithmetic reference model plus literal spot checks.
module tb_johnson_seq_checker;

`ifdef DIR_DETECT_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif
  localparam int LOCK = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic [2:0] code = 3'b000;

  logic [2:0] index8, index2;
  logic       locked8, locked2, dir8, dir2, ill8, ill2, seq8, seq2;
  logic [7:0] err8;
  logic [1:0] err2;

  int n_checks = 0;
  int n_err    = 0;

  johnson_seq_checker #(.LOCK_COUNT(LOCK), .ERR_W(8)) dut8 (
    .clock(clock), .reset(reset), .code_valid(code_valid), .code(code),
    .index(index8), .locked(locked8), .dir(dir8), .illegal_err(ill8),
    .seq_err(seq8), .err_count(err8)
  );

  johnson_seq_checker #(.LOCK_COUNT(LOCK), .ERR_W(2)) dut2 (
    .clock(clock), .reset(reset), .code_valid(code_valid), .code(code),
    .index(index2), .locked(locked2), .dir(dir2), .illegal_err(ill2),
    .seq_err(seq2), .err_count(err2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ring position of each code (-1 = illegal), steps as differences mod 6.
  int pos_of [8] = '{0, 1, -1, 2, 5, -1, 4, 3};
  int m_state = 0;  // 0 hunt, 1 sync, 2 locked
  int m_last = 0, m_good = 0, m_dir = 0, m_idx = 0, m_locked = 0;
  int m_ill = 0, m_seq = 0, m_e8 = 0, m_e2 = 0;

  always @(posedge clock or negedge reset) begin
    int p, d, ns, nl, ng, ndir, nidx, nill, nseq, want;
    bit acc;
    if (!reset) begin
      m_state <= 0; m_last <= 0; m_good <= 0; m_dir <= 0; m_idx <= 0;
      m_locked <= 0; m_ill <= 0; m_seq <= 0; m_e8 <= 0; m_e2 <= 0;
    end else begin
      ns = m_state; nl = m_last; ng = m_good; ndir = m_dir; nidx = m_idx;
      nill = 0; nseq = 0;
      want = (m_dir != 0) ? 5 : 1;
      if (code_valid) begin
        p = pos_of[code];
        if (p < 0) begin
          nill = 1; ns = 0; ng = 0;
        end else begin
          nidx = p;
          d = (p - m_last + 6) % 6;
          if (m_state == 0) begin
            nl = p; ng = 0; ns = 1;
          end else if (m_state == 1 && d != 0) begin
            if (m_good == 0) begin
              acc = (d == 1) || (DIR_EN && d == 5);
              if (acc) ndir = (d == 5) ? 1 : 0;
            end else begin
              acc = (d == want) && (DIR_EN || want == 1);
            end
            nl = p;
            if (acc) begin
              ng = m_good + 1;
              if (ng == LOCK) ns = 2;
            end else ng = 0;
          end else if (m_state == 2 && d != 0) begin
            nl = p;
            if (d != want || (!DIR_EN && want == 5)) begin
              nseq = 1; ng = 0; ns = 1;
            end
          end
        end
      end
      m_state <= ns; m_last <= nl; m_good <= ng; m_dir <= ndir; m_idx <= nidx;
      m_locked <= (ns == 2) ? 1 : 0;
      m_ill <= nill; m_seq <= nseq;
      if (nill != 0 || nseq != 0) begin
        if (m_e8 < 255) m_e8 <= m_e8 + 1;
        if (m_e2 < 3) m_e2 <= m_e2 + 1;
      end
    end
  end

  always @(negedge clock) begin
    chk("index8", 32'(index8), m_idx);
    chk("index2", 32'(index2), m_idx);
    chk("locked8", 32'(locked8), m_locked);
    chk("locked2", 32'(locked2), m_locked);
    chk("dir8", 32'(dir8), m_dir);
    chk("dir2", 32'(dir2), m_dir);
    chk("illegal8", 32'(ill8), m_ill);
    chk("illegal2", 32'(ill2), m_ill);
    chk("seq8", 32'(seq8), m_seq);
    chk("seq2", 32'(seq2), m_seq);
    chk("err8", 32'(err8), m_e8);
    chk("err2", 32'(err2), m_e2);
  end

  task automatic feed(input logic v, input logic [2:0] c);
    @(negedge clock);
    code_valid = v;
    code = c;
    @(posedge clock);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " index"}, 32'(index8), 0);
    chk({tag, " locked"}, 32'(locked8), 0);
    chk({tag, " dir"}, 32'(dir8), 0);
    chk({tag, " illegal"}, 32'(ill8), 0);
    chk({tag, " seq"}, 32'(seq8), 0);
    chk({tag, " err8"}, 32'(err8), 0);
    chk({tag, " err2"}, 32'(err2), 0);
    chk({tag, " locked2"}, 32'(locked2), 0);
  endtask

  logic [2:0] wrap_codes [5] = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b001};
  int         wrap_idx   [5] = '{3, 4, 5, 0, 1};
  logic [2:0] bad_codes  [5] = '{3'b101, 3'b010, 3'b101, 3'b010, 3'b101};

  initial begin
    #8;
    all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // Lock onto a forward stream
    feed(1'b1, 3'b000);
    feed(1'b1, 3'b001);
    feed(1'b1, 3'b011);
    chk("t1 not yet locked", 32'(locked8), 0);
    feed(1'b1, 3'b111);
    chk("t1 locked", 32'(locked8), 1);
    chk("t1 index", 32'(index8), 3);
    chk("t1 err", 32'(err8), 0);

    // Hold and wrap while locked
    for (int i = 0; i < 5; i++) begin
      feed(1'b1, wrap_codes[i]);
      chk("t2 index", 32'(index8), wrap_idx[i]);
      chk("t2 locked", 32'(locked8), 1);
      chk("t2 pulses", 32'({ill8, seq8}), 0);
    end

    // Bad step from 001 to 111, then relock
    feed(1'b1, 3'b111);
    chk("t3 seq_err", 32'(seq8), 1);
    chk("t3 unlocked", 32'(locked8), 0);
    chk("t3 err", 32'(err8), 1);
    feed(1'b1, 3'b110);
    chk("t3 seq one-shot", 32'(seq8), 0);
    feed(1'b1, 3'b100);
    feed(1'b1, 3'b000);
    chk("t3 relocked", 32'(locked8), 1);

    // Invalid cycle carrying an illegal code is ignored
    feed(1'b0, 3'b010);
    chk("idle no pulse", 32'(ill8), 0);
    chk("idle locked holds", 32'(locked8), 1);

    // Illegal code while locked
    feed(1'b1, 3'b010);
    chk("t4 illegal", 32'(ill8), 1);
    chk("t4 index held", 32'(index8), 0);
    chk("t4 err", 32'(err8), 2);
    chk("t4 unlocked", 32'(locked8), 0);

    // Reverse stream
    feed(1'b1, 3'b000);
    feed(1'b1, 3'b100);
    feed(1'b1, 3'b110);
    feed(1'b1, 3'b111);
    chk("t5 dir", 32'(dir8), DIR_EN ? 1 : 0);
    chk("t5 locked", 32'(locked8), DIR_EN ? 1 : 0);
    feed(1'b1, 3'b100);
    chk("t5 seq_err", 32'(seq8), DIR_EN ? 1 : 0);
    chk("t5 err", 32'(err8), DIR_EN ? 3 : 2);

    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) feed(1'b1, bad_codes[i]);
    chk("t6 err2 saturated", 32'(err2), 3);
    chk("t6 err8", 32'(err8), DIR_EN ? 8 : 7);

    // Reset in the middle of a stream
    feed(1'b1, 3'b000);
    feed(1'b1, 3'b001);
    feed(1'b1, 3'b011);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    all_zero("midreset");
    @(negedge clock);
    reset = 1'b1;
    feed(1'b1, 3'b011);
    chk("post-reset index", 32'(index8), 2);
    chk("post-reset locked", 32'(locked8), 0);
    feed(1'b0, 3'b000);
    feed(1'b0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
